// File: rtl/control_sequencer_if.sv
// control_sequencer_if: opcode/flag inputs and per-cycle datapath strobes of the Mini SRC control unit.
interface control_sequencer_if;
   logic [4:0] opcode;
   logic       con_ff;
   logic       incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_CON_FF;
   logic       ram_read, ram_write, MDR_read;
   logic       Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
   logic [3:0] ALU_op;
   logic [4:0] BusDataSelect;
   logic       run, illegal_op;
   modport master (
      input  opcode, con_ff,
      output incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_CON_FF, ram_read, ram_write, MDR_read,
             Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, ALU_op, BusDataSelect, run, illegal_op
   );
   modport slave (
      output opcode, con_ff,
      input  incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_CON_FF, ram_read, ram_write, MDR_read,
             Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, ALU_op, BusDataSelect, run, illegal_op
   );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini SRC fetch/decode/execute FSM driving the datapath strobes.
module control_sequencer #(
   parameter int         MEM_WAIT = 1,
   parameter logic [4:0] SEL_NONE = 5'b00000,
   parameter logic [4:0] SEL_ZLO  = 5'b10011,
   parameter logic [4:0] SEL_PC   = 5'b10100,
   parameter logic [4:0] SEL_MDR  = 5'b10101,
   parameter logic [4:0] SEL_C    = 5'b01100,
   parameter logic [3:0] ALU_ADD  = 4'b0011,
   parameter logic [3:0] ALU_SUB  = 4'b0100,
   parameter logic [3:0] ALU_AND  = 4'b0101,
   parameter logic [3:0] ALU_OR   = 4'b0110
) (
   input logic clock,
   input logic clear,
   control_sequencer_if.master cs
);
   localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
   localparam logic [4:0] OP_BR = 5'b10010, OP_JR = 5'b10100, OP_NOP = 5'b11010, OP_HALT = 5'b11011;
   localparam logic [1:0] W = 2'(MEM_WAIT - 1);
   typedef enum logic [4:0] {
      RESET, F0, F1, F2, F3, DECODE, E1, E2, E3, M1, M2, M3, S1, S2, B1, B2, B3, B4, J1, HALT
   } state_t;
   state_t     state_q;
   logic [1:0] cnt_q;
   logic [4:0] op_q;
   logic       legal, is_mem, base, rtype;
   logic [3:0] alu;
   always_comb begin
      legal  = cs.opcode inside {OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                 OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JR, OP_NOP, OP_HALT};
      is_mem = op_q == OP_LD || op_q == OP_ST;
      base   = is_mem || op_q == OP_LDI;
      rtype  = op_q inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
      alu    = op_q == OP_SUB ? ALU_SUB :
               (op_q == OP_AND || op_q == OP_ANDI) ? ALU_AND :
               (op_q == OP_OR || op_q == OP_ORI) ? ALU_OR : ALU_ADD;
   end
   // op_q latches the opcode at DECODE so execute-phase strobes depend only on registered state
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q <= RESET;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         case (state_q)
            RESET:  state_q <= F0;
            F0:     begin state_q <= F1; cnt_q <= '0; end
            F1:     if (cnt_q == W) state_q <= F2; else cnt_q <= cnt_q + 2'd1;
            F2:     state_q <= F3;
            F3:     state_q <= DECODE;
            DECODE: begin
               op_q    <= cs.opcode;
               state_q <= (!legal || cs.opcode == OP_NOP) ? F0 :
                          cs.opcode == OP_BR ? B1 :
                          cs.opcode == OP_JR ? J1 :
                          cs.opcode == OP_HALT ? HALT : E1;
            end
            E1:     state_q <= E2;
            E2:     state_q <= E3;
            E3:     begin state_q <= op_q == OP_LD ? M1 : op_q == OP_ST ? S1 : F0; cnt_q <= '0; end
            M1:     if (cnt_q == W) state_q <= M2; else cnt_q <= cnt_q + 2'd1;
            M2:     state_q <= M3;
            S1:     state_q <= S2;
            B1:     state_q <= B2;
            B2:     state_q <= B3;
            B3:     state_q <= B4;
            HALT:   state_q <= HALT;
            default: state_q <= F0;
         endcase
      end
   end
   always_comb begin
      cs.incPC = 1'b0; cs.e_PC = 1'b0; cs.e_IR = 1'b0; cs.e_Y = 1'b0; cs.e_Z = 1'b0;
      cs.e_MDR = 1'b0; cs.e_MAR = 1'b0; cs.e_CON_FF = 1'b0;
      cs.ram_read = 1'b0; cs.ram_write = 1'b0; cs.MDR_read = 1'b0;
      cs.Gra = 1'b0; cs.Grb = 1'b0; cs.Grc = 1'b0; cs.e_Rin = 1'b0; cs.e_Rout = 1'b0;
      cs.BAout = 1'b0; cs.imm_sel = 1'b0;
      cs.ALU_op = 4'b0000;
      cs.BusDataSelect = SEL_NONE;
      cs.illegal_op = 1'b0;
      cs.run = state_q != RESET && state_q != HALT;
      case (state_q)
         F0:     begin cs.BusDataSelect = SEL_PC; cs.e_MAR = 1'b1; cs.incPC = 1'b1; end
         F1, M1: cs.ram_read = 1'b1;
         F2, M2: begin cs.MDR_read = 1'b1; cs.e_MDR = 1'b1; end
         F3:     begin cs.BusDataSelect = SEL_MDR; cs.e_IR = 1'b1; end
         DECODE: cs.illegal_op = !legal;
         E1:     begin cs.Grb = 1'b1; cs.e_Y = 1'b1; cs.BAout = base; cs.e_Rout = !base; end
         E2: begin
            cs.e_Z = 1'b1; cs.Grc = rtype; cs.e_Rout = rtype; cs.imm_sel = !rtype;
            cs.BusDataSelect = rtype ? SEL_NONE : SEL_C; cs.ALU_op = alu;
         end
         E3: begin
            cs.BusDataSelect = SEL_ZLO; cs.e_MAR = is_mem; cs.Gra = !is_mem; cs.e_Rin = !is_mem;
         end
         M3:     begin cs.BusDataSelect = SEL_MDR; cs.Gra = 1'b1; cs.e_Rin = 1'b1; end
         S1:     begin cs.Gra = 1'b1; cs.e_Rout = 1'b1; cs.e_MDR = 1'b1; end
         S2:     cs.ram_write = 1'b1;
         B1:     begin cs.Gra = 1'b1; cs.e_Rout = 1'b1; cs.e_CON_FF = 1'b1; end
         B2:     begin cs.BusDataSelect = SEL_PC; cs.e_Y = 1'b1; end
         B3:     begin cs.BusDataSelect = SEL_C; cs.imm_sel = 1'b1; cs.ALU_op = ALU_ADD; cs.e_Z = 1'b1; end
         B4:     begin cs.BusDataSelect = SEL_ZLO; cs.e_PC = cs.con_ff; end
         J1:     begin cs.Gra = 1'b1; cs.e_Rout = 1'b1; cs.e_PC = 1'b1; end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction stream against a per-instruction cycle-list model, scoreboard-checked.
module tb_control_sequencer;
   localparam int MW = 2;
   localparam logic [4:0] S_NONE = 5'b00000, S_ZLO = 5'b10011, S_PC = 5'b10100, S_MDR = 5'b10101, S_C = 5'b01100;
   typedef struct packed {
      logic incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_CON_FF, ram_read, ram_write, MDR_read;
      logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
      logic [3:0] alu;
      logic [4:0] bus;
      logic run, ill;
   } out_t;
   logic clk = 1'b0;
   logic clear;
   int   checks = 0, errors = 0, cycle = 0;
   out_t q[$];
   control_sequencer_if cs ();
   control_sequencer #(.MEM_WAIT(MW)) dut (.clock(clk), .clear(clear), .cs(cs));
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;
   always @(negedge clk) begin
      out_t a, e;
      a = {cs.incPC, cs.e_PC, cs.e_IR, cs.e_Y, cs.e_Z, cs.e_MDR, cs.e_MAR, cs.e_CON_FF, cs.ram_read, cs.ram_write,
           cs.MDR_read, cs.Gra, cs.Grb, cs.Grc, cs.e_Rin, cs.e_Rout, cs.BAout, cs.imm_sel, cs.ALU_op,
           cs.BusDataSelect, cs.run, cs.illegal_op};
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %h want %h (alu %h/%h bus %h/%h)", cycle, a, e, a.alu, e.alu, a.bus, e.bus);
         end
         checks++;
         if ((a.e_Rout && a.bus != S_NONE) || (a.ram_read && a.ram_write)) begin
            errors++;
            $display("FAIL exclusivity cycle %0d: e_Rout=%b bus=%h rd=%b wr=%b want no overlap", cycle, a.e_Rout, a.bus, a.ram_read, a.ram_write);
         end
      end
   end
   function automatic out_t mk();
      out_t t = '0;
      t.run = 1'b1;
      return t;
   endfunction
   function automatic logic [3:0] alu_of(input logic [4:0] opc);
      case (opc)
         5'b00100: return 4'b0100;
         5'b00101, 5'b01101: return 4'b0101;
         5'b00110, 5'b01110: return 4'b0110;
         default: return 4'b0011;
      endcase
   endfunction
   task automatic cyc(input out_t t);
      @(posedge clk);
      #1 q.push_back(t);
   endtask
   task automatic do_reset();
      clear = 1'b0;
      cyc('0);
      clear = 1'b1;
   endtask
   // Expected output list for one instruction from F0 to the cycle before the next F0
   task automatic instr(input logic [4:0] opc, input logic cf, input int stop);
      out_t o[$];
      out_t t;
      t = mk(); t.bus = S_PC; t.e_MAR = 1; t.incPC = 1; o.push_back(t);
      repeat (MW) begin t = mk(); t.ram_read = 1; o.push_back(t); end
      t = mk(); t.MDR_read = 1; t.e_MDR = 1; o.push_back(t);
      t = mk(); t.bus = S_MDR; t.e_IR = 1; o.push_back(t);
      t = mk(); t.ill = !(opc inside {0, 1, 2, 3, 4, 5, 6, 12, 13, 14, 18, 20, 26, 27}); o.push_back(t);
      if (opc inside {3, 4, 5, 6, 12, 13, 14, 0, 1, 2}) begin
         t = mk(); t.Grb = 1; t.e_Y = 1;
         if (opc <= 2) t.BAout = 1; else t.e_Rout = 1;
         o.push_back(t);
         t = mk(); t.e_Z = 1; t.alu = alu_of(opc);
         if (opc inside {3, 4, 5, 6}) begin t.Grc = 1; t.e_Rout = 1; end
         else begin t.bus = S_C; t.imm_sel = 1; end
         o.push_back(t);
         t = mk(); t.bus = S_ZLO;
         if (opc == 0 || opc == 2) t.e_MAR = 1; else begin t.Gra = 1; t.e_Rin = 1; end
         o.push_back(t);
         if (opc == 0) begin
            repeat (MW) begin t = mk(); t.ram_read = 1; o.push_back(t); end
            t = mk(); t.MDR_read = 1; t.e_MDR = 1; o.push_back(t);
            t = mk(); t.bus = S_MDR; t.Gra = 1; t.e_Rin = 1; o.push_back(t);
         end
         if (opc == 2) begin
            t = mk(); t.Gra = 1; t.e_Rout = 1; t.e_MDR = 1; o.push_back(t);
            t = mk(); t.ram_write = 1; o.push_back(t);
         end
      end else if (opc == 18) begin
         t = mk(); t.Gra = 1; t.e_Rout = 1; t.e_CON_FF = 1; o.push_back(t);
         t = mk(); t.bus = S_PC; t.e_Y = 1; o.push_back(t);
         t = mk(); t.bus = S_C; t.imm_sel = 1; t.alu = 4'b0011; t.e_Z = 1; o.push_back(t);
         t = mk(); t.bus = S_ZLO; t.e_PC = cf; o.push_back(t);
      end else if (opc == 20) begin
         t = mk(); t.Gra = 1; t.e_Rout = 1; t.e_PC = 1; o.push_back(t);
      end else if (opc == 27) begin
         repeat (20) o.push_back('0);
      end
      for (int i = 0; i < o.size() && i < stop; i++) begin
         cyc(o[i]);
         if (i == 0) begin cs.opcode = opc; cs.con_ff = cf; end
      end
   endtask
   initial begin
      logic [4:0] opc;
      clear = 1'b0; cs.opcode = '0; cs.con_ff = 1'b0;
      do_reset();
      instr(5'b00000, 1'b0, MW + 8);
      do_reset();
      instr(5'b00011, 1'b0, 99);
      instr(5'b10010, 1'b1, 99);
      instr(5'b10010, 1'b0, 99);
      instr(5'b00010, 1'b0, 99);
      instr(5'b11111, 1'b0, 99);
      instr(5'b11011, 1'b0, 99);
      do_reset();
      repeat (60) begin
         opc = 5'($urandom_range(0, 31));
         instr(opc, 1'($urandom_range(0, 1)), 99);
         if (opc == 5'b11011) do_reset();
      end
      @(posedge clk);
      @(negedge clk);
      #1 checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected cycles unconsumed, want 0", q.size());
      end
      $display("%0d/%0d checks passed", checks - errors, checks);
      $finish;
   end
endmodule
